// File: rtl/mult_share_arbiter_if.sv
// Requester-side bus of the shared multiplier: packed per-requester operand
// lanes, per-requester valid/ready on both directions, one shared result bus.
interface mult_share_arbiter_if #(
  parameter int BITWIDTH = 32,
  parameter int NREQ     = 4
);
  logic [NREQ-1:0]          req_valid;
  logic [NREQ-1:0]          req_ready;
  logic [NREQ*BITWIDTH-1:0] req_a;
  logic [NREQ*BITWIDTH-1:0] req_b;
  logic [NREQ-1:0]          rsp_valid;
  logic [NREQ-1:0]          rsp_ready;
  logic [2*BITWIDTH-1:0]    rsp_y;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_y
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_y
  );
endinterface

// File: rtl/mult_share_arbiter.sv
// Round-robin time-sharing of one combinational BITWIDTH x BITWIDTH multiplier
// among NREQ requesters, with registered operands and a held product.
module multiply #(
  parameter int BITWIDTH = 32
) (
  input  logic [BITWIDTH-1:0]   a,
  input  logic [BITWIDTH-1:0]   b,
  output logic [2*BITWIDTH-1:0] y
);
  assign y = {{BITWIDTH{1'b0}}, a} * {{BITWIDTH{1'b0}}, b};
endmodule

module mult_share_arbiter #(
  parameter int BITWIDTH = 32,
  parameter int NREQ     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  mult_share_arbiter_if.slave  bus,
  output logic                 busy
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t                state_q;
  logic [BITWIDTH-1:0]   op_a_q, op_b_q;
  logic [IW-1:0]         owner_q, rr_ptr_q;
  logic [2*BITWIDTH-1:0] prod_q, prod_d;
  logic [NREQ-1:0]       rsp_valid_q;
  logic                  busy_q;

  logic                  grant_vld, grant_win, take;
  logic [IW-1:0]         grant_idx;

  // Search starts just past the last grant, so the previous winner is last.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!grant_vld && bus.req_valid[(int'(rr_ptr_q) + k) % NREQ]) begin
        grant_vld = 1'b1;
        grant_idx = IW'((int'(rr_ptr_q) + k) % NREQ);
      end
    end
  end

  assign grant_win     = (state_q == IDLE) || ((state_q == RESP) && bus.rsp_ready[owner_q]);
  assign take          = grant_win && grant_vld;
  assign bus.req_ready = take ? (NREQ'(1) << grant_idx) : '0;

  // The multiplier sees only the registered operands.
  multiply #(.BITWIDTH(BITWIDTH)) u_multiply (
    .a (op_a_q),
    .b (op_b_q),
    .y (prod_d)
  );

  // NOTE: sequential state uses non-blocking assignments only; reset is
  // asynchronous and drops any in-flight transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      op_a_q      <= '0;
      op_b_q      <= '0;
      owner_q     <= '0;
      rr_ptr_q    <= IW'(NREQ - 1);
      prod_q      <= '0;
      rsp_valid_q <= '0;
      busy_q      <= 1'b0;
    end else if (take) begin
      op_a_q      <= bus.req_a[grant_idx*BITWIDTH +: BITWIDTH];
      op_b_q      <= bus.req_b[grant_idx*BITWIDTH +: BITWIDTH];
      owner_q     <= grant_idx;
      rr_ptr_q    <= grant_idx;
      state_q     <= EXEC;
      rsp_valid_q <= '0;
      busy_q      <= 1'b1;
    end else begin
      unique case (state_q)
        EXEC: begin
          prod_q      <= prod_d;
          state_q     <= RESP;
          rsp_valid_q <= NREQ'(1) << owner_q;
        end
        RESP: begin
          if (bus.rsp_ready[owner_q]) begin
            state_q     <= IDLE;
            rsp_valid_q <= '0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_y     = prod_q;
  assign busy          = busy_q;
endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter: reset, single op with hold, round-robin
// streaming, back-to-back grant, backpressure, mid-operation reset, boundary operands.
module tb_mult_share_arbiter;
  localparam int BW = 32;
  localparam int NR = 4;

  logic clk;
  logic rst;
  logic busy;
  int   n_total;
  int   n_pass;

  mult_share_arbiter_if #(.BITWIDTH(BW), .NREQ(NR)) bus ();

  mult_share_arbiter #(.BITWIDTH(BW), .NREQ(NR)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  // Inputs change 2 time units after a rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_op(input int i, input logic [BW-1:0] a, input logic [BW-1:0] b);
    bus.req_a[i*BW +: BW] = a;
    bus.req_b[i*BW +: BW] = b;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    bus.req_valid = '0;
    bus.rsp_ready = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    rst = 1'b1;
    tick();
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    rst = 1'b0;

    // Single request, full-scale operands, response held three cycles.
    set_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    bus.req_valid = 4'b0001;
    #1;
    check("single_req_ready", 64'(bus.req_ready), 64'h1);
    tick();
    bus.req_valid = '0;
    check("single_exec_busy", 64'(busy), 64'd1);
    check("single_exec_no_rsp", 64'(bus.rsp_valid), 64'd0);
    tick();
    for (int c = 0; c < 3; c++) begin
      check("single_hold_valid", 64'(bus.rsp_valid), 64'h1);
      check("single_hold_y", bus.rsp_y, 64'hFFFF_FFFE_0000_0001);
      tick();
    end
    bus.rsp_ready = 4'b0001;
    #1;
    check("single_last_valid", 64'(bus.rsp_valid), 64'h1);
    tick();
    bus.rsp_ready = '0;
    check("single_cleared_valid", 64'(bus.rsp_valid), 64'd0);
    check("single_idle_busy", 64'(busy), 64'd0);

    // All requesters valid continuously, responses accepted at once.
    do_reset();
    for (int i = 0; i < NR; i++) set_op(i, BW'(i + 1), 32'd10);
    bus.req_valid = 4'b1111;
    bus.rsp_ready = 4'b1111;
    #1;
    for (int g = 0; g < 5; g++) begin
      int exp_w;
      exp_w = g % NR;
      check("rr_grant", 64'(bus.req_ready), 64'(4'b0001 << exp_w));
      tick();
      check("rr_exec_busy", 64'(busy), 64'd1);
      check("rr_exec_no_rsp", 64'(bus.rsp_valid), 64'd0);
      tick();
      check("rr_rsp_valid", 64'(bus.rsp_valid), 64'(4'b0001 << exp_w));
      check("rr_rsp_y", bus.rsp_y, 64'((exp_w + 1) * 10));
      check("rr_resp_busy", 64'(busy), 64'd1);
    end
    bus.req_valid = '0;
    tick();
    check("rr_drain_busy", 64'(busy), 64'd0);
    bus.rsp_ready = '0;

    // Owner 1 accepts its product in the same cycle requester 2 is granted.
    do_reset();
    set_op(1, 32'd3, 32'd5);
    bus.req_valid = 4'b0010;
    #1;
    check("b2b_grant1", 64'(bus.req_ready), 64'h2);
    tick();
    bus.req_valid = '0;
    tick();
    check("b2b_rsp1_y", bus.rsp_y, 64'd15);
    set_op(2, 32'd7, 32'd6);
    bus.req_valid = 4'b0100;
    bus.rsp_ready = 4'b0010;
    #1;
    check("b2b_grant2", 64'(bus.req_ready), 64'h4);
    tick();
    bus.req_valid = '0;
    bus.rsp_ready = '0;
    check("b2b_exec_no_rsp", 64'(bus.rsp_valid), 64'd0);
    check("b2b_exec_busy", 64'(busy), 64'd1);
    tick();
    check("b2b_rsp2_valid", 64'(bus.rsp_valid), 64'h4);
    check("b2b_rsp2_y", bus.rsp_y, 64'd42);

    // Owner 3 stalls for 10 cycles while requester 0 waits; bit 0 of rsp_ready is ignored.
    set_op(3, 32'd9, 32'd9);
    bus.req_valid = 4'b1000;
    bus.rsp_ready = 4'b0100;
    #1;
    check("bp_grant3", 64'(bus.req_ready), 64'h8);
    tick();
    bus.rsp_ready = '0;
    set_op(0, 32'd2, 32'd3);
    bus.req_valid = 4'b0001;
    tick();
    bus.rsp_ready = 4'b0001;
    for (int c = 0; c < 10; c++) begin
      #1;
      check("bp_no_grant", 64'(bus.req_ready), 64'd0);
      check("bp_rsp_valid", 64'(bus.rsp_valid), 64'h8);
      check("bp_rsp_y", bus.rsp_y, 64'd81);
      tick();
    end
    bus.rsp_ready = 4'b1000;
    #1;
    check("bp_release_grant0", 64'(bus.req_ready), 64'h1);
    tick();
    bus.rsp_ready = '0;
    bus.req_valid = '0;
    tick();
    check("bp_rsp0_valid", 64'(bus.rsp_valid), 64'h1);
    check("bp_rsp0_y", bus.rsp_y, 64'd6);
    bus.rsp_ready = 4'b0001;
    tick();
    bus.rsp_ready = '0;

    // Asynchronous reset while requester 1 is in EXEC.
    set_op(1, 32'd4, 32'd4);
    bus.req_valid = 4'b0010;
    tick();
    bus.req_valid = '0;
    check("rst_pre_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    check("rst_async_busy", 64'(busy), 64'd0);
    check("rst_async_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    tick();
    check("rst_held_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    rst = 1'b0;

    // Restart: requester 0 beats 1; boundary operands.
    set_op(0, 32'd0, 32'hDEAD_BEEF);
    set_op(1, 32'd1, 32'h8000_0000);
    bus.req_valid = 4'b0011;
    #1;
    check("post_rst_grant0", 64'(bus.req_ready), 64'h1);
    tick();
    bus.req_valid = 4'b0010;
    tick();
    check("zero_rsp_valid", 64'(bus.rsp_valid), 64'h1);
    check("zero_rsp_y", bus.rsp_y, 64'd0);
    bus.rsp_ready = 4'b0001;
    #1;
    check("post_rst_grant1", 64'(bus.req_ready), 64'h2);
    tick();
    bus.req_valid = '0;
    bus.rsp_ready = '0;
    tick();
    check("msb_rsp_valid", 64'(bus.rsp_valid), 64'h2);
    check("msb_rsp_y", bus.rsp_y, 64'h0000_0000_8000_0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
